// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit carry-lookahead slice, LSB nibble first.
// Optional subtract mode: define NIBBLE_SERIAL_ADDER_SUB_EN.
module nibble_serial_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = $clog2(NIB);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nstate;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   logic             w_sub;
   logic [WIDTH-1:0] w_bin;
   logic [3:0]       w_an;
   logic [3:0]       w_bn;
   logic [3:0]       w_g;
   logic [3:0]       w_p;
   logic [4:0]       w_c;
   logic [3:0]       w_s;
   logic             w_last;
   logic [WIDTH-1:0] w_fin;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   assign w_sub = sub;
`else
   assign w_sub = 1'b0;
`endif

   assign w_bin = w_sub ? ~b : b;

   assign w_an = r_a[3:0];
   assign w_bn = r_b[3:0];
   assign w_g  = w_an & w_bn;
   assign w_p  = w_an | w_bn;

   assign w_c[0] = r_carry;
   assign w_c[1] = w_g[0] | (w_p[0] & r_carry);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                 | (w_p[1] & w_p[0] & r_carry);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                 | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & r_carry);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2])
                 | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
   assign w_s = w_an ^ w_bn ^ w_c[3:0];

   assign w_last = (r_cnt == CW'(NIB - 1));
   // The vacated top of r_a collects result nibbles, so sum stays stable in RUN
   assign w_fin  = {w_s, r_a[WIDTH-1:4]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nstate;
   end

   always_comb begin
      w_nstate  = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_nstate = RUN;
         end
         RUN: begin
            if (w_last) w_nstate = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_nstate = IDLE;
         end
         default: w_nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= w_bin;
                  r_carry <= w_sub | cin;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_a     <= w_fin;
               r_b     <= {4'b0000, r_b[WIDTH-1:4]};
               r_carry <= w_c[4];
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_sum  <= w_fin;
                  r_cout <= w_c[4];
                  r_ovf  <= w_c[3] ^ w_c[4];
                  r_zero <= ~|w_fin;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;
   assign zero     = r_zero;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=32).
// Subtract vectors run when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder;

   localparam int W   = 32;
   localparam int NIB = W / 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;
   logic         zero;

   int n_run;
   int n_fail;

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      .sub      (sub),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow),
      .zero     (zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [31:0] ta,
                        input logic [31:0] tb,
                        input logic        tc,
                        input logic        ts,
                        input logic [31:0] es,
                        input logic        ec,
                        input logic        eo,
                        input logic        ez,
                        input string       tag);
      in_valid = 1'b1;
      a   = ta;
      b   = tb;
      cin = tc;
      sub = ts;
      chk({tag, "_rdy0"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a   = $urandom;
      b   = $urandom;
      cin = 1'b1;
      sub = 1'b0;
      chk({tag, "_busy"}, 32'(in_ready), 32'd0);
      repeat (NIB - 1) @(posedge clk);
      #1;
      chk({tag, "_early"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
      chk({tag, "_zero"}, 32'(zero), 32'(ez));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_pop"}, 32'(out_valid), 32'd0);
      chk({tag, "_rdy1"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      n_run     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a   = '0;
      b   = '0;
      cin = 1'b0;
      sub = 1'b0;
      #1;
      chk("rst_vld", 32'(out_valid), 32'd0);
      chk("rst_rdy", 32'(in_ready), 32'd1);
      chk("rst_sum", sum, 32'd0);
      chk("rst_flags", {29'd0, cout, overflow, zero}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      do_op(32'h0000000F, 32'h00000001, 1'b0, 1'b0,
            32'h00000010, 1'b0, 1'b0, 1'b0, "t1");
      do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0,
            32'h00000000, 1'b1, 1'b0, 1'b1, "t2");
      do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
            32'h80000000, 1'b0, 1'b1, 1'b0, "t3");

      // Backpressure: hold result, refuse new operands
      in_valid = 1'b1;
      a = 32'h00000001;
      b = 32'h00000002;
      cin = 1'b0;
      @(posedge clk); #1;
      a = 32'h10000000;
      b = 32'h20000000;
      repeat (NIB) @(posedge clk);
      #1;
      chk("t4_vld", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t4_hold_sum", sum, 32'h00000003);
         chk("t4_hold_vld", 32'(out_valid), 32'd1);
         chk("t4_hold_rdy", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("t4_idle_rdy", 32'(in_ready), 32'd1);
      chk("t4_idle_vld", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t4_acc", 32'(in_ready), 32'd0);
      repeat (NIB - 1) @(posedge clk);
      #1;
      chk("t4b_early", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("t4b_vld", 32'(out_valid), 32'd1);
      chk("t4b_sum", sum, 32'h30000000);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset mid-RUN aborts without presenting a partial result
      in_valid = 1'b1;
      a = 32'hDEADBEEF;
      b = 32'h01010101;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t5_vld", 32'(out_valid), 32'd0);
      chk("t5_sum", sum, 32'd0);
      chk("t5_rdy", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0,
            32'h23456789, 1'b0, 1'b0, 1'b0, "t5b");

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      do_op(32'h00000005, 32'h00000007, 1'b0, 1'b1,
            32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, "t6a");
      do_op(32'h80000000, 32'h00000001, 1'b1, 1'b1,
            32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, "t6b");
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
